// File: rtl/circuito_exp6.sv
// circuito_exp6: Simon-style memory game top level.
// A fixed 16-step sequence of one-hot moves is replayed on the LEDs, one more
// element per round. The player's button presses are then checked against it.
// The game ends with a win, a wrong move or a timeout.
// Optional macro SEGUNDA_MEMORIA_EN adds a second ROM (the first one reversed),
// selected by memoria=1. When the macro is undefined, memoria is ignored.
module circuito_exp6 #(
    parameter int LED_ON_CYCLES  = 500,
    parameter int LED_OFF_CYCLES = 250,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic [3:0] botoes,
    input  logic       dificuldade,
    input  logic       memoria,
    output logic       ganhou,
    output logic       perdeu,
    output logic       pronto,
    output logic       timeout,
    output logic [3:0] leds,
    output logic       db_igual,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogadafeita,
    output logic       db_clock,
    output logic       db_iniciar,
    output logic       db_tem_jogada,
    output logic [6:0] db_seqCont,
    output logic       db_mostra_leds
);

    localparam int MAX_ON_OFF = (LED_ON_CYCLES > LED_OFF_CYCLES) ? LED_ON_CYCLES : LED_OFF_CYCLES;
    localparam int MAX_CYC    = (MAX_ON_OFF > TIMEOUT_CYCLES) ? MAX_ON_OFF : TIMEOUT_CYCLES;
    localparam int TW         = $clog2(MAX_CYC + 1);

    // The numeric values of the states are the codes shown on db_estado.
    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        MOSTRA_LED     = 4'h2,
        PAUSA_LED      = 4'h3,
        INICIA_JOGADA  = 4'h4,
        ESPERA_JOGADA  = 4'h5,
        REGISTRA       = 4'h6,
        COMPARACAO     = 4'h7,
        PROXIMA_JOGADA = 4'h8,
        PROXIMA_RODADA = 4'h9,
        GANHOU_ST      = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        PERDEU_ST      = 4'hE
    } state_t;

    state_t        state_reg;
    logic [3:0]    endereco_reg;
    logic [3:0]    rodada_reg;
    logic [3:0]    jogada_reg;
    logic [TW-1:0] timer_reg;
    logic          tem_jogada_prev_reg;
    logic          ganhou_reg;
    logic          perdeu_reg;
    logic          pronto_reg;
    logic          timeout_reg;

    logic          tem_jogada;
    logic          jogada_detectada;
    logic [3:0]    rom_addr;
    logic [3:0]    rom_data;
    logic [3:0]    ultima_rodada;
    logic          igual;
    logic          fim_mostra;
    logic          fim_pausa;
    logic          fim_espera;

    // Fixed game sequence, one-hot moves.
    function automatic logic [3:0] rom0_lookup(input logic [3:0] addr);
        case (addr)
            4'd0:    rom0_lookup = 4'b0001;
            4'd1:    rom0_lookup = 4'b1000;
            4'd2:    rom0_lookup = 4'b0100;
            4'd3:    rom0_lookup = 4'b1000;
            4'd4:    rom0_lookup = 4'b0100;
            4'd5:    rom0_lookup = 4'b0010;
            4'd6:    rom0_lookup = 4'b0001;
            4'd7:    rom0_lookup = 4'b0001;
            4'd8:    rom0_lookup = 4'b0010;
            4'd9:    rom0_lookup = 4'b0010;
            4'd10:   rom0_lookup = 4'b0100;
            4'd11:   rom0_lookup = 4'b0100;
            4'd12:   rom0_lookup = 4'b1000;
            4'd13:   rom0_lookup = 4'b1000;
            4'd14:   rom0_lookup = 4'b0001;
            default: rom0_lookup = 4'b0100;
        endcase
    endfunction

    // Active-low 7-segment pattern, bit order gfedcba.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] on;
        case (v)
            4'h0:    on = 7'b0111111;
            4'h1:    on = 7'b0000110;
            4'h2:    on = 7'b1011011;
            4'h3:    on = 7'b1001111;
            4'h4:    on = 7'b1100110;
            4'h5:    on = 7'b1101101;
            4'h6:    on = 7'b1111101;
            4'h7:    on = 7'b0000111;
            4'h8:    on = 7'b1111111;
            4'h9:    on = 7'b1101111;
            4'hA:    on = 7'b1110111;
            4'hB:    on = 7'b1111100;
            4'hC:    on = 7'b0111001;
            4'hD:    on = 7'b1011110;
            4'hE:    on = 7'b1111001;
            default: on = 7'b1110001;
        endcase
        hex7 = ~on;
    endfunction

`ifdef SEGUNDA_MEMORIA_EN
    // The second ROM is the first one read backwards: 15-k == ~k on 4 bits.
    assign rom_addr = memoria ? ~endereco_reg : endereco_reg;
`else
    logic memoria_unused;
    assign memoria_unused = memoria;
    assign rom_addr       = endereco_reg;
`endif

    assign rom_data         = rom0_lookup(rom_addr);
    assign tem_jogada       = |botoes;
    assign jogada_detectada = tem_jogada & ~tem_jogada_prev_reg;
    assign ultima_rodada    = dificuldade ? 4'd15 : 4'd7;
    assign igual            = (jogada_reg == rom_data);
    assign fim_mostra       = (timer_reg == TW'(LED_ON_CYCLES - 1));
    assign fim_pausa        = (timer_reg == TW'(LED_OFF_CYCLES - 1));
    assign fim_espera       = (timer_reg == TW'(TIMEOUT_CYCLES - 1));

    // Game controller: state, counters, move register and final flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg           <= INICIAL;
            endereco_reg        <= '0;
            rodada_reg          <= '0;
            jogada_reg          <= '0;
            timer_reg           <= '0;
            tem_jogada_prev_reg <= 1'b0;
            ganhou_reg          <= 1'b0;
            perdeu_reg          <= 1'b0;
            pronto_reg          <= 1'b0;
            timeout_reg         <= 1'b0;
        end else begin
            tem_jogada_prev_reg <= tem_jogada;
            case (state_reg)
                INICIAL, GANHOU_ST, PERDEU_ST, FIM_TIMEOUT: begin
                    if (jogar) begin
                        ganhou_reg  <= 1'b0;
                        perdeu_reg  <= 1'b0;
                        pronto_reg  <= 1'b0;
                        timeout_reg <= 1'b0;
                        state_reg   <= PREPARACAO;
                    end
                end
                PREPARACAO: begin
                    rodada_reg   <= '0;
                    endereco_reg <= '0;
                    timer_reg    <= '0;
                    ganhou_reg   <= 1'b0;
                    perdeu_reg   <= 1'b0;
                    pronto_reg   <= 1'b0;
                    timeout_reg  <= 1'b0;
                    state_reg    <= MOSTRA_LED;
                end
                MOSTRA_LED: begin
                    if (fim_mostra) begin
                        timer_reg <= '0;
                        state_reg <= PAUSA_LED;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                PAUSA_LED: begin
                    if (fim_pausa) begin
                        timer_reg <= '0;
                        if (endereco_reg == rodada_reg) begin
                            state_reg <= INICIA_JOGADA;
                        end else begin
                            endereco_reg <= endereco_reg + 1'b1;
                            state_reg    <= MOSTRA_LED;
                        end
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                INICIA_JOGADA: begin
                    endereco_reg <= '0;
                    timer_reg    <= '0;
                    state_reg    <= ESPERA_JOGADA;
                end
                ESPERA_JOGADA: begin
                    // The move is captured on the press edge itself, so a
                    // short press is not lost; registra is the settle cycle.
                    if (jogada_detectada) begin
                        jogada_reg <= botoes;
                        state_reg  <= REGISTRA;
                    end else if (fim_espera) begin
                        perdeu_reg  <= 1'b1;
                        timeout_reg <= 1'b1;
                        pronto_reg  <= 1'b1;
                        state_reg   <= FIM_TIMEOUT;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                REGISTRA: begin
                    state_reg <= COMPARACAO;
                end
                COMPARACAO: begin
                    if (!igual) begin
                        perdeu_reg <= 1'b1;
                        pronto_reg <= 1'b1;
                        state_reg  <= PERDEU_ST;
                    end else if (endereco_reg < rodada_reg) begin
                        state_reg <= PROXIMA_JOGADA;
                    end else if (rodada_reg == ultima_rodada) begin
                        ganhou_reg <= 1'b1;
                        pronto_reg <= 1'b1;
                        state_reg  <= GANHOU_ST;
                    end else begin
                        state_reg <= PROXIMA_RODADA;
                    end
                end
                PROXIMA_JOGADA: begin
                    endereco_reg <= endereco_reg + 1'b1;
                    timer_reg    <= '0;
                    state_reg    <= ESPERA_JOGADA;
                end
                PROXIMA_RODADA: begin
                    rodada_reg   <= rodada_reg + 1'b1;
                    endereco_reg <= '0;
                    timer_reg    <= '0;
                    state_reg    <= MOSTRA_LED;
                end
                default: begin
                    state_reg <= INICIAL;
                end
            endcase
        end
    end

    assign ganhou         = ganhou_reg;
    assign perdeu         = perdeu_reg;
    assign pronto         = pronto_reg;
    assign timeout        = timeout_reg;
    assign leds           = (state_reg == MOSTRA_LED) ? rom_data : 4'b0000;
    assign db_mostra_leds = (state_reg == MOSTRA_LED) || (state_reg == PAUSA_LED);
    assign db_igual       = igual;
    assign db_clock       = clock;
    assign db_iniciar     = jogar;
    assign db_tem_jogada  = tem_jogada;

    // Debug 7-segment digits: address, ROM data, state, move, round.
    logic [3:0] seg_in  [5];
    logic [6:0] seg_out [5];

    assign seg_in[0] = endereco_reg;
    assign seg_in[1] = rom_data;
    assign seg_in[2] = state_reg;
    assign seg_in[3] = jogada_reg;
    assign seg_in[4] = rodada_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_seg
            assign seg_out[gi] = hex7(seg_in[gi]);
        end
    endgenerate

    assign db_contagem    = seg_out[0];
    assign db_memoria     = seg_out[1];
    assign db_estado      = seg_out[2];
    assign db_jogadafeita = seg_out[3];
    assign db_seqCont     = seg_out[4];

endmodule

// File: tb/tb_circuito_exp6.sv
// Testbench for circuito_exp6: scenario tasks plus a LED-display scoreboard.
module tb_circuito_exp6;

    localparam int LED_ON  = 500;
    localparam int TMO     = 5000;
    localparam int BUDGET  = 15000;

    // Sequence table, address 15 in the top nibble down to address 0.
    localparam logic [63:0] ROM0_PACK = {4'h4, 4'h1, 4'h8, 4'h8, 4'h4, 4'h4, 4'h2, 4'h2,
                                         4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h8, 4'h1};

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       jogar = 1'b0;
    logic [3:0] botoes = 4'b0000;
    logic       dificuldade = 1'b0;
    logic       memoria = 1'b0;
    logic       ganhou, perdeu, pronto, timeout;
    logic [3:0] leds;
    logic       db_igual;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_seqCont;
    logic       db_clock, db_iniciar, db_tem_jogada, db_mostra_leds;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    circuito_exp6 dut (
        .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
        .dificuldade(dificuldade), .memoria(memoria),
        .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .timeout(timeout),
        .leds(leds), .db_igual(db_igual), .db_contagem(db_contagem),
        .db_memoria(db_memoria), .db_estado(db_estado),
        .db_jogadafeita(db_jogadafeita), .db_clock(db_clock),
        .db_iniciar(db_iniciar), .db_tem_jogada(db_tem_jogada),
        .db_seqCont(db_seqCont), .db_mostra_leds(db_mostra_leds)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: seg = 7'h40; 4'h1: seg = 7'h79; 4'h2: seg = 7'h24; 4'h3: seg = 7'h30;
            4'h4: seg = 7'h19; 4'h5: seg = 7'h12; 4'h6: seg = 7'h02; 4'h7: seg = 7'h78;
            4'h8: seg = 7'h00; 4'h9: seg = 7'h10; 4'hA: seg = 7'h08; 4'hB: seg = 7'h03;
            4'hC: seg = 7'h46; 4'hD: seg = 7'h21; 4'hE: seg = 7'h06; default: seg = 7'h0E;
        endcase
    endfunction

    function automatic logic [3:0] exp_rom(input int k);
        int idx;
        idx = k;
`ifdef SEGUNDA_MEMORIA_EN
        if (memoria) idx = 15 - k;
`endif
        exp_rom = ROM0_PACK[idx*4 +: 4];
    endfunction

    // Scoreboard: each displayed element is compared with the queue head, and
    // its on-time is checked when it goes dark.
    int         on_cnt = 0;
    logic [3:0] cur_led = 4'b0000;
    always @(negedge clock) begin
        if (reset) begin
            on_cnt = 0;
        end else if (leds !== 4'b0000) begin
            if (on_cnt == 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL led_unexpected: leds=%b shown, no element required", leds);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    if (leds !== e || db_mostra_leds !== 1'b1) begin
                        errors++;
                        $display("FAIL led_value: leds=%b mostra=%b, required leds=%b mostra=1",
                                 leds, db_mostra_leds, e);
                    end
                end
                cur_led = leds;
            end else if (leds !== cur_led) begin
                checks++;
                errors++;
                $display("FAIL led_stable: leds=%b changed from %b mid-display", leds, cur_led);
            end
            on_cnt++;
        end else if (on_cnt != 0) begin
            checks++;
            if (on_cnt != LED_ON) begin
                errors++;
                $display("FAIL led_duration: on for %0d cycles, required %0d", on_cnt, LED_ON);
            end
            on_cnt = 0;
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_state(input logic [3:0] code, input int max_cycles, input string name);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < max_cycles && !hit; n++) begin
            @(negedge clock);
            if (db_estado === seg(code)) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: db_estado=%b, state %h not reached within %0d cycles",
                     name, db_estado, code, max_cycles);
        end
    endtask

    task automatic press(input logic [3:0] v);
        tick;
        botoes = v;
        repeat (10) tick;
        botoes = 4'b0000;
        tick;
    endtask

    task automatic start_game;
        exp_q.push_back(exp_rom(0));
        tick;
        jogar = 1'b1;
        repeat (5) tick;
        jogar = 1'b0;
    endtask

    // Plays round r correctly; when nxt is set, the next round's display is
    // queued before the final move of this round.
    task automatic play_round(input int r, input bit nxt);
        for (int k = 0; k <= r; k++) begin
            wait_state(4'h5, BUDGET, "wait_move");
            if (k == r && nxt) begin
                for (int j = 0; j <= r + 1; j++) exp_q.push_back(exp_rom(j));
            end
            press(exp_rom(k));
        end
    endtask

    task automatic test_reset;
        tick;
        reset = 1'b1;
        tick;
        @(negedge clock);
        checks++;
        if (db_estado !== seg(4'h0) || leds !== 4'b0000 || db_mostra_leds !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: estado=%b leds=%b mostra=%b, required %b 0000 0",
                     db_estado, leds, db_mostra_leds, seg(4'h0));
        end
        checks++;
        if ({ganhou, perdeu, pronto, timeout} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: g/p/pr/t=%b, required 0000", {ganhou, perdeu, pronto, timeout});
        end
        checks++;
        if (db_contagem !== seg(4'h0) || db_seqCont !== seg(4'h0) || db_jogadafeita !== seg(4'h0)) begin
            errors++;
            $display("FAIL reset_counters: cont=%b seq=%b jog=%b, required %b",
                     db_contagem, db_seqCont, db_jogadafeita, seg(4'h0));
        end
        checks++;
        if (db_iniciar !== jogar || db_clock !== clock || db_tem_jogada !== 1'b0) begin
            errors++;
            $display("FAIL reset_copies: iniciar=%b clock=%b tem=%b, required %b %b 0",
                     db_iniciar, db_clock, db_tem_jogada, jogar, clock);
        end
        tick;
        reset = 1'b0;
    endtask

    task automatic test_start_display;
        start_game;
        @(negedge clock);
        checks++;
        if (db_mostra_leds !== 1'b1 || db_estado !== seg(4'h2)) begin
            errors++;
            $display("FAIL start_display: mostra=%b estado=%b, required 1 %b",
                     db_mostra_leds, db_estado, seg(4'h2));
        end
        wait_state(4'h5, 2000, "start_wait5");
        checks++;
        if (db_mostra_leds !== 1'b0 || exp_q.size() != 0 || db_contagem !== seg(4'h0)) begin
            errors++;
            $display("FAIL start_after: mostra=%b pending=%0d cont=%b, required 0 0 %b",
                     db_mostra_leds, exp_q.size(), db_contagem, seg(4'h0));
        end
    endtask

    task automatic test_rounds;
        play_round(0, 1'b1);
        wait_state(4'h2, 50, "round2_display");
        checks++;
        if (db_seqCont !== seg(4'h1)) begin
            errors++;
            $display("FAIL round2_seq: db_seqCont=%b, required %b", db_seqCont, seg(4'h1));
        end
        play_round(1, 1'b1);
        wait_state(4'h2, 50, "round3_display");
        checks++;
        if (db_seqCont !== seg(4'h2) || db_mostra_leds !== 1'b1) begin
            errors++;
            $display("FAIL round3_seq: db_seqCont=%b mostra=%b, required %b 1",
                     db_seqCont, db_mostra_leds, seg(4'h2));
        end
        do_reset;
    endtask

    task automatic test_timeout;
        int n;
        dificuldade = 1'b1;
        start_game;
        play_round(0, 1'b1);
        play_round(1, 1'b1);
        wait_state(4'h5, BUDGET, "timeout_wait5");
        n = 1;
        for (int i = 0; i < 2 * TMO; i++) begin
            @(negedge clock);
            if (db_estado !== seg(4'h5)) break;
            n++;
        end
        checks++;
        if (n != TMO || db_estado !== seg(4'hD)) begin
            errors++;
            $display("FAIL timeout_wait: %0d cycles waiting, estado=%b, required %0d then %b",
                     n, db_estado, TMO, seg(4'hD));
        end
        checks++;
        if ({ganhou, perdeu, pronto, timeout} !== 4'b0111) begin
            errors++;
            $display("FAIL timeout_flags: g/p/pr/t=%b, required 0111", {ganhou, perdeu, pronto, timeout});
        end
        dificuldade = 1'b0;
        do_reset;
    endtask

    task automatic test_wrong;
        start_game;
        wait_state(4'h5, 2000, "wrong_wait5");
        tick;
        botoes = 4'b0010;
        #1;
        checks++;
        if (db_tem_jogada !== 1'b1) begin
            errors++;
            $display("FAIL tem_jogada: db_tem_jogada=%b, required 1", db_tem_jogada);
        end
        repeat (10) tick;
        botoes = 4'b0000;
        wait_state(4'hE, 50, "wrong_lost");
        checks++;
        if ({ganhou, perdeu, pronto, timeout} !== 4'b0110 || db_igual !== 1'b0) begin
            errors++;
            $display("FAIL wrong_flags: g/p/pr/t=%b igual=%b, required 0110 0",
                     {ganhou, perdeu, pronto, timeout}, db_igual);
        end
        checks++;
        if (db_jogadafeita !== seg(4'h2)) begin
            errors++;
            $display("FAIL wrong_move: db_jogadafeita=%b, required %b", db_jogadafeita, seg(4'h2));
        end
        do_reset;
    endtask

    task automatic test_win;
        start_game;
        for (int r = 0; r < 8; r++) play_round(r, r < 7);
        wait_state(4'hA, 50, "win_state");
        checks++;
        if ({ganhou, perdeu, pronto, timeout} !== 4'b1010 || db_seqCont !== seg(4'h7)) begin
            errors++;
            $display("FAIL win_flags: g/p/pr/t=%b seq=%b, required 1010 %b",
                     {ganhou, perdeu, pronto, timeout}, db_seqCont, seg(4'h7));
        end
        exp_q.push_back(exp_rom(0));
        tick;
        jogar = 1'b1;
        tick;
        jogar = 1'b0;
        @(negedge clock);
        checks++;
        if ({ganhou, perdeu, pronto, timeout} !== 4'b0000 || db_estado !== seg(4'h1)) begin
            errors++;
            $display("FAIL restart: g/p/pr/t=%b estado=%b, required 0000 %b",
                     {ganhou, perdeu, pronto, timeout}, db_estado, seg(4'h1));
        end
        wait_state(4'h2, 5, "restart_display");
        do_reset;
    endtask

    task automatic test_memoria_reset;
        memoria = 1'b1;
        start_game;
        repeat (100) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        checks++;
        if (leds !== 4'b0000 || db_estado !== seg(4'h0) || db_mostra_leds !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: leds=%b estado=%b mostra=%b, required 0000 %b 0",
                     leds, db_estado, db_mostra_leds, seg(4'h0));
        end
        memoria = 1'b0;
    endtask

    initial begin
        test_reset;
        test_start_display;
        test_rounds;
        test_timeout;
        test_wrong;
        test_win;
        test_memoria_reset;
        repeat (5) tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/circuito_exp6.md
Name: circuito_exp6

Overview:
- "Memory game" (Simon-style) top level: stores a fixed 16-step sequence of one-hot 4-bit moves.
- Each round it replays the sequence prefix on the LEDs, then checks the player's button presses against it.
- Tracks win, loss and timeout; exposes a debug bundle of 7-segment and raw signals for the board.

Parameters:
- LED_ON_CYCLES, 500, clock cycles each sequence element is shown on leds.
- LED_OFF_CYCLES, 250, blank cycles after each shown element.
- TIMEOUT_CYCLES, 5000, cycles allowed waiting for a move before timeout (5 s at 1 kHz).

Ports:
- clock  in  1  system clock (1 kHz nominal)
- reset  in  1  synchronous, active-high reset
- jogar  in  1  start/restart game (level, sampled each cycle)
- botoes  in  4  player buttons, one-hot expected
- dificuldade  in  1  0 = 8 rounds to win, 1 = 16 rounds to win
- memoria  in  1  sequence ROM select (see Optional Feature)
- ganhou  out  1  game won
- perdeu  out  1  game lost (wrong move or timeout)
- pronto  out  1  game finished
- timeout  out  1  loss was caused by timeout
- leds  out  4  sequence display
- db_igual  out  1  registered move == ROM data
- db_contagem  out  7  7-seg of sequence address counter
- db_memoria  out  7  7-seg of ROM data
- db_estado  out  7  7-seg of state code
- db_jogadafeita  out  7  7-seg of registered move
- db_clock  out  1  copy of clock
- db_iniciar  out  1  copy of jogar
- db_tem_jogada  out  1  OR of botoes (combinational)
- db_seqCont  out  7  7-seg of round counter
- db_mostra_leds  out  1  high while the sequence is being displayed

Behaviour:
- Single clock domain; reset is synchronous, active-high.
- Reset puts the FSM in the inicial state; clears all counters and the move register; all flag outputs 0; leds 0.
- 7-seg encoding: active-low, bit order gfedcba, hex digits 0-F.
- ROM 0 contents (addr 0..15): 0001, 1000, 0100, 1000, 0100, 0010, 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001, 0100.
- Move detection: rising edge of OR(botoes), registered. On that edge the full botoes value is latched into the move register, with one-cycle latency.
- Buttons are ignored outside espera_jogada.
- FSM states and codes:
  - 0 inicial: wait for jogar=1, then go to 1.
  - 1 preparacao: round counter=0, address=0, clear flags, go to 2.
  - 2 mostra_led: leds=ROM[address] for LED_ON_CYCLES, then go to 3.
  - 3 pausa_led: leds=0 for LED_OFF_CYCLES.
    - If address==round, go to 4.
    - Otherwise address++ and go to 2.
  - 4 inicia_jogada: address=0, timeout counter cleared, go to 5.
  - 5 espera_jogada: go to 6 on a detected move. After TIMEOUT_CYCLES cycles with no move, go to D.
  - 6 registra: latch move, go to 7.
  - 7 comparacao:
    - Mismatch: go to E.
    - Match and address<round: go to 8.
    - Match and address==round and round==last (7 if dificuldade=0, 15 if 1): go to A.
    - Match and address==round, not last: go to 9.
  - 8 proxima_jogada: address++, timeout counter cleared, go to 5.
  - 9 proxima_rodada: round++, address=0, go to 2.
  - A ganhou: ganhou=1, pronto=1.
  - E perdeu: perdeu=1, pronto=1.
  - D fim_timeout: perdeu=1, timeout=1, pronto=1.
  - From A, E or D: jogar=1 goes to 1; final flags clear there.
- db_mostra_leds=1 in states 2 and 3 only.
- leds is nonzero only in state 2.
- dificuldade and memoria are sampled continuously; changing them mid-game takes effect at the next comparison/ROM read.
- Reset mid-game returns to inicial within one cycle regardless of state.
- jogar held high for several cycles starts the game only once; the sequence begins in state 1.

Optional Feature:
- Macro SEGUNDA_MEMORIA_EN.
- Defined: second ROM present, memoria=1 selects it. ROM 1[k] = ROM 0[15-k].
- Undefined: memoria ignored, ROM 0 always used.

Test Plan:
- Reset 1 cycle, then jogar=1 for 5 cycles -> db_mostra_leds=1, leds=0001 for 500 cycles, then db_mostra_leds falls; db_estado shows 5.
- Round 1: press 0001 for 10 cycles -> round 2 display 0001 then 1000; then press 0001, 1000 -> round 3 display begins (db_seqCont=2).
- dificuldade=1: after 2 correct rounds, no press for 10000 cycles -> timeout=1, perdeu=1, pronto=1, ganhou=0, db_estado=D.
- Wrong press (0010 in round 1) -> perdeu=1, pronto=1, timeout=0, db_igual=0.
- dificuldade=0: all 8 rounds correct -> ganhou=1, pronto=1; then jogar=1 restarts with flags cleared.
- With SEGUNDA_MEMORIA_EN and memoria=1 -> first displayed led = 0100; reset mid-display -> leds=0, state 0.
